// File: rtl/router_input_fifo_if.sv
// Handshake bundle between a router input port buffer and its neighbours:
// upstream write/credit side plus the head-flit view used by LBDR and the crossbar.
interface router_input_fifo_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int AXIS       = 2,
   parameter int PTR_W      = $clog2(DEPTH)
);
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] flit_in;
   logic                  credit_out;
   logic                  read_en;
   logic                  empty;
   logic                  full;
   logic [PTR_W:0]        count;
   logic [DATA_WIDTH-1:0] flit_out;
   logic [2:0]            flit_type;
   logic [AXIS-1:0]       dst_addr;
   logic                  overflow_err;
   logic                  framing_err;

   modport master (
      output valid_in, flit_in, read_en,
      input  credit_out, empty, full, count, flit_out, flit_type, dst_addr,
             overflow_err, framing_err
   );

   modport slave (
      input  valid_in, flit_in, read_en,
      output credit_out, empty, full, count, flit_out, flit_type, dst_addr,
             overflow_err, framing_err
   );
endinterface

// File: rtl/router_input_fifo.sv
// Per-port first-word-fall-through flit buffer with credit return and
// sticky overflow / packet-framing error flags.
//
// state | meaning
// IDLE  | between packets, next accepted flit must be a HEADER
// PKT   | inside a packet, expecting BODY or TAIL
module router_input_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int AXIS       = 2,
   parameter int PTR_W      = $clog2(DEPTH)
) (
   input logic                clk,
   input logic                rst,
   router_input_fifo_if.slave fifo
);
   localparam logic [2:0] HEADER = 3'b001;
   localparam logic [2:0] BODY   = 3'b010;
   localparam logic [2:0] TAIL   = 3'b100;

   typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W:0]        count_q;
   logic                  credit_q;
   logic                  overflow_q;
   logic                  framing_q;
   logic                  empty_w;
   logic                  full_w;
   logic                  wr;
   logic                  rd;
   logic [2:0]            type_in;
   logic                  frame_bad;
   state_t                state;
   state_t                state_nxt;

   // Flags come from the registered count, so full is always the pre-edge view.
   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == (PTR_W+1)'(DEPTH));
   assign wr      = fifo.valid_in & ~full_w;
   assign rd      = fifo.read_en & ~empty_w;
   assign type_in = fifo.flit_in[DATA_WIDTH-1 -: 3];

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= fifo.flit_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         credit_q   <= 1'b0;
         overflow_q <= 1'b0;
         framing_q  <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr, rd})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
         credit_q   <= rd;
         overflow_q <= overflow_q | (fifo.valid_in & full_w);
         framing_q  <= framing_q | frame_bad;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A HEADER inside a packet is taken as a fresh packet start, so PKT holds.
   always_comb begin
      state_nxt = state;
      if (wr) begin
         case (type_in)
            HEADER:  state_nxt = PKT;
            TAIL:    state_nxt = IDLE;
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      frame_bad = 1'b0;
      if (wr) begin
         case (type_in)
            HEADER:     frame_bad = (state == PKT);
            BODY, TAIL: frame_bad = (state == IDLE);
            default:    frame_bad = 1'b1;
         endcase
      end
   end

   assign fifo.empty        = empty_w;
   assign fifo.full         = full_w;
   assign fifo.count        = count_q;
   assign fifo.credit_out   = credit_q;
   assign fifo.overflow_err = overflow_q;
   assign fifo.framing_err  = framing_q;
   assign fifo.flit_out     = mem[rd_ptr];
   assign fifo.flit_type    = fifo.flit_out[DATA_WIDTH-1 -: 3];
   assign fifo.dst_addr     = fifo.flit_out[AXIS-1:0];
endmodule

// File: tb/tb_router_input_fifo.sv
// Directed bench for router_input_fifo: a queue scoreboard tracks stored flits,
// popped flits are compared against it and status/credit/error flags every cycle.
module tb_router_input_fifo;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   logic [DW-1:0] m_q[$];
   logic          m_ovf;
   logic          exp_ferr;

   router_input_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AXIS(2)) bus ();

   router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AXIS(2)) dut (
      .clk  (clk),
      .rst  (rst),
      .fifo (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.valid_in = 1'b0;
      bus.flit_in  = '0;
      bus.read_en  = 1'b0;
      @(posedge clk);
      #1;
      m_q.delete();
      m_ovf    = 1'b0;
      exp_ferr = 1'b0;
      chk("rst_count",  DW'(bus.count), 0);
      chk("rst_empty",  DW'(bus.empty), 1);
      chk("rst_full",   DW'(bus.full), 0);
      chk("rst_credit", DW'(bus.credit_out), 0);
      chk("rst_ovf",    DW'(bus.overflow_err), 0);
      chk("rst_frm",    DW'(bus.framing_err), 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic step(input logic v, input logic [DW-1:0] f, input logic r);
      logic wr;
      logic rd;
      @(negedge clk);
      bus.valid_in = v;
      bus.flit_in  = f;
      bus.read_en  = r;
      wr = v && (m_q.size() < DEPTH);
      rd = r && (m_q.size() > 0);
      #1;
      if (rd) chk("pop_flit", bus.flit_out, m_q[0]);
      @(posedge clk);
      #1;
      if (rd) void'(m_q.pop_front());
      if (wr) m_q.push_back(f);
      if (v && !wr) m_ovf = 1'b1;
      chk("count",    DW'(bus.count), DW'(m_q.size()));
      chk("empty",    DW'(bus.empty), DW'(m_q.size() == 0));
      chk("full",     DW'(bus.full), DW'(m_q.size() == DEPTH));
      chk("credit",   DW'(bus.credit_out), DW'(rd));
      chk("overflow", DW'(bus.overflow_err), DW'(m_ovf));
      chk("framing",  DW'(bus.framing_err), DW'(exp_ferr));
      if (m_q.size() > 0) begin
         chk("head_type", DW'(bus.flit_type), DW'(m_q[0][DW-1 -: 3]));
         chk("head_dst",  DW'(bus.dst_addr), DW'(m_q[0][1:0]));
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      m_ovf = 1'b0;
      exp_ferr = 1'b0;
      rst = 1'b1;
      bus.valid_in = 1'b0;
      bus.flit_in  = '0;
      bus.read_en  = 1'b0;

      // single header in, single pop out
      do_reset();
      step(1'b1, 32'h2000_0003, 1'b0);
      chk("t1_type", DW'(bus.flit_type), 32'd1);
      chk("t1_dst",  DW'(bus.dst_addr), 32'd3);
      step(1'b0, '0, 1'b1);
      chk("t1_credit", DW'(bus.credit_out), 32'd1);
      step(1'b0, '0, 1'b0);

      // fill, overflow with a dropped BODY (must not disturb framing), drain
      do_reset();
      step(1'b1, 32'h2000_0001, 1'b0);
      step(1'b1, 32'h4000_0010, 1'b0);
      step(1'b1, 32'h4000_0020, 1'b0);
      step(1'b1, 32'h8000_0030, 1'b0);
      chk("t2_full", DW'(bus.full), 32'd1);
      step(1'b1, 32'h4000_00FF, 1'b0);
      chk("t2_ovf",   DW'(bus.overflow_err), 32'd1);
      chk("t2_count", DW'(bus.count), 32'd4);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);

      // write+read while full is rejected; at count 2 both happen
      do_reset();
      step(1'b1, 32'h2000_0101, 1'b0);
      step(1'b1, 32'h4000_0102, 1'b0);
      step(1'b1, 32'h4000_0103, 1'b0);
      step(1'b1, 32'h8000_0104, 1'b0);
      step(1'b1, 32'h2000_0105, 1'b1);
      chk("t3_count3", DW'(bus.count), 32'd3);
      chk("t3_ovf",    DW'(bus.overflow_err), 32'd1);
      step(1'b0, '0, 1'b1);
      step(1'b1, 32'h2000_0106, 1'b1);
      chk("t3_count2", DW'(bus.count), 32'd2);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);

      // pointer wrap over 10 flits
      do_reset();
      for (int i = 0; i < 10; i++) begin
         logic [2:0] t;
         t = (i == 0) ? 3'b001 : ((i == 9) ? 3'b100 : 3'b010);
         step(1'b1, {t, 29'(i * 7 + 1)}, (i >= 3));
      end
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

      // framing: BODY first
      do_reset();
      exp_ferr = 1'b1;
      step(1'b1, 32'h4000_0001, 1'b0);
      chk("t5_stored", DW'(bus.count), 32'd1);

      // framing: H,B,H
      do_reset();
      step(1'b1, 32'h2000_0002, 1'b0);
      step(1'b1, 32'h4000_0002, 1'b0);
      exp_ferr = 1'b1;
      step(1'b1, 32'h2000_0003, 1'b0);

      // framing: invalid type 011
      do_reset();
      exp_ferr = 1'b1;
      step(1'b1, 32'h6000_0001, 1'b0);

      // framing: clean packet
      do_reset();
      step(1'b1, 32'h2000_0001, 1'b0);
      step(1'b1, 32'h4000_0002, 1'b0);
      step(1'b1, 32'h8000_0003, 1'b0);
      chk("t8_clean", DW'(bus.framing_err), 32'd0);

      // reset with 3 flits and a latched error, then read on empty
      do_reset();
      exp_ferr = 1'b1;
      step(1'b1, 32'h4000_0011, 1'b0);
      step(1'b1, 32'h2000_0012, 1'b0);
      step(1'b1, 32'h4000_0013, 1'b0);
      do_reset();
      step(1'b0, '0, 1'b1);
      chk("t9_credit", DW'(bus.credit_out), 32'd0);
      chk("t9_empty",  DW'(bus.empty), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/router_input_fifo.md
Name: router_input_fifo

Overview:
- Per-port input buffer of the 2x2 mesh router; sits directly upstream of the LBDR routing stage.
- Stores incoming flits in a first-word-fall-through FIFO.
- Presents the head flit's type and destination address to LBDR and the head flit to the crossbar.
- Returns credits to the upstream neighbour and flags overflow and packet-framing violations.

Parameters:
- DATA_WIDTH, 32, flit width in bits.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- AXIS, 2, destination address width (AXIS/2 bits per coordinate, x in low half).
- PTR_W, log2(DEPTH), pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  upstream presents flit_in this cycle
- flit_in  in  DATA_WIDTH  incoming flit; [DATA_WIDTH-1 -: 3] = type, [AXIS-1:0] = destination
- credit_out  out  1  one-cycle pulse, one slot freed, to upstream credit counter
- read_en  in  1  allocator/crossbar pops the head flit
- empty  out  1  FIFO holds no flit (to LBDR)
- full  out  1  FIFO holds DEPTH flits
- count  out  PTR_W+1  occupancy, 0..DEPTH
- flit_out  out  DATA_WIDTH  head flit (combinational from storage)
- flit_type  out  3  flit_out[DATA_WIDTH-1 -: 3] (to LBDR)
- dst_addr  out  AXIS  flit_out[AXIS-1:0] (to LBDR)
- overflow_err  out  1  sticky: write attempted while full
- framing_err  out  1  sticky: illegal flit-type sequence on write side

Behaviour:
- Flit types: HEADER 3'b001, BODY 3'b010, TAIL 3'b100. Any other value is invalid.
- Reset values:
  - Pointers, count, credit_out, overflow_err and framing_err are 0.
  - empty = 1, full = 0, framing FSM = IDLE.
  - Storage is not reset.
  - Upstream's credit counter starts at DEPTH; this block sends no credits at reset.
- Write: wr = valid_in & ~full.
  - Stores flit_in at wr_ptr; wr_ptr increments mod DEPTH.
  - valid_in & full drops the flit, leaves state unchanged and sets overflow_err.
- Read: rd = read_en & ~empty.
  - rd_ptr increments mod DEPTH.
  - read_en while empty is ignored; no credit and no error.
- Simultaneous wr and rd: count unchanged, both pointers advance.
  - When full, the write is rejected even if a read occurs in the same cycle. Full is evaluated on the pre-edge count.
  - When empty, a same-cycle write is stored; the read is ignored.
- Status flags:
  - count updates on the clock edge: +1 on wr only, -1 on rd only.
  - empty = (count == 0); full = (count == DEPTH). Both derive from registered count.
- Fall-through: a flit written at edge N is visible on flit_out/flit_type/dst_addr, with empty = 0, after edge N. LBDR can sample it at edge N+1.
- flit_out is don't-care while empty; verification must not check it then.
- Credit: credit_out is registered and equals rd of the previous cycle, i.e. a 1-cycle pulse one cycle after each successful pop. Back-to-back pops give back-to-back pulses.
- Framing FSM (IDLE, PKT), evaluated only on accepted writes (wr = 1):
  - IDLE + HEADER -> PKT.
  - IDLE + BODY or TAIL -> set framing_err, stay IDLE.
  - PKT + BODY -> stay PKT.
  - PKT + TAIL -> IDLE.
  - PKT + HEADER -> set framing_err, stay PKT (treated as new packet start).
  - Invalid type in any state -> set framing_err, state unchanged.
  - The flit is always stored regardless of error.
  - Dropped (overflow) flits do not advance the FSM.
- Sticky errors clear only on rst.
- Reset mid-operation: all contents are discarded. Upstream must reset its credit counter in the same cycle (shared rst).

Test Plan:
- Reset, then write HEADER 0x2000_0003 -> after the edge: empty=0, count=1, flit_type=3'b001, dst_addr=2'b11. Pop -> credit_out high exactly one cycle after the pop edge, empty=1.
- Write 4 flits (H,B,B,T) with no reads -> full=1, count=4. A 5th valid_in -> overflow_err=1, count stays 4. Four pops return the flits in order with 4 credit pulses.
- Full FIFO with valid_in and read_en in the same cycle -> write rejected, overflow_err=1, count=3. From count=2, the same stimulus -> count stays 2, order preserved.
- Pointer wrap: stream 10 flits with interleaved single reads and writes -> output sequence equals input sequence, count never exceeds 4.
- Framing: BODY first after reset -> framing_err=1, flit still stored. Separately, H,B,H -> framing_err=1. Type 3'b011 -> framing_err=1. Clean H,B,T -> framing_err stays 0.
- Reset with 3 flits stored -> next cycle: empty=1, count=0, errors=0, credit_out=0. read_en afterwards has no effect.
